// File: rtl/spi_master_fifo_arbiter.sv
// Round-robin arbiter sharing one SPI TX FIFO write port between NUM_REQ requesters.
// A grant lasts one burst: until a word marked last or MAX_BURST words, never interleaved.
//
// state | meaning
// IDLE  | no owner; picks next requester from prio with wrap-around
// BURST | owner gnt_q drives the FIFO port until last word or forced release
module spi_master_fifo_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST     = 16,
  parameter int LOG_NUM_REQ   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int LOG_MAX_BURST = $clog2(MAX_BURST)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_valid_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  input  logic                          fifo_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic [LOG_MAX_BURST:0]        beat_cnt_o
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [LOG_NUM_REQ:0]   NUM_REQ_W = (LOG_NUM_REQ+1)'(NUM_REQ);
  localparam logic [LOG_NUM_REQ-1:0] LAST_REQ  = LOG_NUM_REQ'(NUM_REQ-1);
  localparam logic [LOG_MAX_BURST:0] BEAT_LAST = (LOG_MAX_BURST+1)'(MAX_BURST-1);

  state_e                 state_q;
  logic [LOG_NUM_REQ-1:0] gnt_q, prio_q, pick;
  logic [LOG_MAX_BURST:0] beat_q;

  logic [NUM_REQ-1:0]     rot;
  logic [LOG_NUM_REQ:0]   off, sum;
  logic                   found;
  logic                   own_valid, own_last, hs, burst_end;

  // Rotate valids so prio sits at bit 0; lowest set bit is the winner offset.
  always_comb begin
    rot   = NUM_REQ'({req_valid_i, req_valid_i} >> prio_q);
    found = 1'b0;
    off   = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = (LOG_NUM_REQ+1)'(j);
      end
    end
    sum = {1'b0, prio_q} + off;
    if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
    pick = sum[LOG_NUM_REQ-1:0];
  end

  always_comb begin
    own_valid   = 1'b0;
    own_last    = 1'b0;
    fifo_data_o = '0;
    req_ready_o = '0;
    grant_o     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == BURST && gnt_q == LOG_NUM_REQ'(i)) begin
        own_valid      = req_valid_i[i];
        own_last       = req_last_i[i];
        fifo_data_o    = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready_o[i] = fifo_ready_i;
        grant_o[i]     = 1'b1;
      end
    end
    fifo_valid_o = own_valid;
    hs           = own_valid && fifo_ready_i;
    burst_end    = hs && (own_last || beat_q == BEAT_LAST);
  end

  assign busy_o     = (state_q == BURST);
  assign beat_cnt_o = beat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      prio_q  <= '0;
      beat_q  <= '0;
    end else if (clr_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= pick;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            prio_q  <= (gnt_q == LAST_REQ) ? '0 : gnt_q + 1'b1;
            beat_q  <= '0;
            state_q <= IDLE;
          end else if (hs) begin
            beat_q <= beat_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_fifo_arbiter.sv
// Directed bench for spi_master_fifo_arbiter: reset, single burst, round robin,
// forced release, backpressure and synchronous clear.
module tb_spi_master_fifo_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clr_i;
  logic [3:0]   req_valid_i;
  logic [127:0] req_data_i;
  logic [3:0]   req_last_i;
  logic [3:0]   req_ready_o;
  logic         fifo_valid_o;
  logic [31:0]  fifo_data_o;
  logic         fifo_ready_i;
  logic [3:0]   grant_o;
  logic         busy_o;
  logic [4:0]   beat_cnt_o;

  int          cnt[4];
  int          blen[4];
  logic [31:0] log_q[$];
  int          n_tot = 0;
  int          n_bad = 0;

  spi_master_fifo_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .fifo_valid_o(fifo_valid_o), .fifo_data_o(fifo_data_o),
    .fifo_ready_i(fifo_ready_i), .grant_o(grant_o), .busy_o(busy_o),
    .beat_cnt_o(beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (!rst_i && fifo_valid_o && fifo_ready_i) log_q.push_back(fifo_data_o);

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int r, input int c);
    return 32'hD000_0000 | (32'(r) << 16) | 32'(c);
  endfunction

  task automatic drive();
    for (int r = 0; r < 4; r++) begin
      req_data_i[r*32 +: 32] = word(r, cnt[r]);
      req_last_i[r] = (blen[r] != 0) ? ((cnt[r] % blen[r]) == blen[r] - 1) : 1'b0;
    end
  endtask

  task automatic set_valid(input logic [3:0] v);
    req_valid_i = v;
    drive();
    #1;
  endtask

  task automatic step();
    logic [3:0] acc;
    acc = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    for (int r = 0; r < 4; r++) if (acc[r]) cnt[r]++;
    drive();
    #1;
  endtask

  task automatic restart(input int b0, input int b1, input int b2, input int b3);
    clr_i = 1'b1;
    set_valid(4'b0000);
    step();
    clr_i = 1'b0;
    for (int r = 0; r < 4; r++) cnt[r] = 0;
    blen[0] = b0; blen[1] = b1; blen[2] = b2; blen[3] = b3;
    log_q.delete();
    drive();
    #1;
  endtask

  task automatic check_log(input int r, input int first, input int n);
    check("log_size", 64'(log_q.size()), 64'(n));
    if (log_q.size() == n)
      for (int k = 0; k < n; k++) check("log_word", 64'(log_q.pop_front()), 64'(word(r, first + k)));
  endtask

  logic [3:0] exp_rr [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                              4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    // reset with random inputs
    rst_i        = 1'b1;
    clr_i        = 1'b0;
    fifo_ready_i = 1'b1;
    req_valid_i  = 4'($urandom);
    req_last_i   = 4'($urandom);
    for (int r = 0; r < 4; r++) req_data_i[r*32 +: 32] = $urandom;
    #12;
    check("rst_fifo_valid", 64'(fifo_valid_o), 0);
    check("rst_fifo_data", 64'(fifo_data_o), 0);
    check("rst_req_ready", 64'(req_ready_o), 0);
    check("rst_grant", 64'(grant_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_beat", 64'(beat_cnt_o), 0);
    for (int r = 0; r < 4; r++) begin cnt[r] = 0; blen[r] = 0; end
    req_valid_i = 4'b0000;
    drive();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_busy", 64'(busy_o), 0);
    end
    check("idle_grant", 64'(grant_o), 0);

    // single burst from requester 1
    blen[1] = 3;
    log_q.delete();
    set_valid(4'b0010);
    check("sb_pre_grant", 64'(grant_o), 0);
    step();
    check("sb_grant", 64'(grant_o), 64'b0010);
    check("sb_busy", 64'(busy_o), 1);
    check("sb_fvalid", 64'(fifo_valid_o), 1);
    check("sb_data0", 64'(fifo_data_o), 64'(word(1, 0)));
    check("sb_ready", 64'(req_ready_o), 64'b0010);
    check("sb_beat0", 64'(beat_cnt_o), 0);
    step();
    check("sb_beat1", 64'(beat_cnt_o), 1);
    check("sb_data1", 64'(fifo_data_o), 64'(word(1, 1)));
    step();
    check("sb_beat2", 64'(beat_cnt_o), 2);
    check("sb_last", 64'(req_last_i[1]), 1);
    step();
    check("sb_end_busy", 64'(busy_o), 0);
    check("sb_end_grant", 64'(grant_o), 0);
    check("sb_end_beat", 64'(beat_cnt_o), 0);
    check_log(1, 0, 3);
    set_valid(4'b0110);
    step();
    check("sb_next_grant", 64'(grant_o), 64'b0100);

    // round robin, all requesters, 2-word bursts
    restart(2, 2, 2, 2);
    check("rr_clr_busy", 64'(busy_o), 0);
    set_valid(4'b1111);
    for (int i = 0; i < 13; i++) begin
      step();
      check("rr_grant", 64'(grant_o), 64'(exp_rr[i]));
    end
    check("rr_data", 64'(fifo_data_o), 64'(word(0, 2)));
    check("rr_log_size", 64'(log_q.size()), 8);
    if (log_q.size() == 8)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 2; k++) check("rr_log", 64'(log_q.pop_front()), 64'(word(r, k)));

    // forced release after 16 words
    restart(0, 0, 0, 2);
    set_valid(4'b0100);
    step();
    check("fr_grant", 64'(grant_o), 64'b0100);
    for (int k = 1; k < 16; k++) begin
      step();
      check("fr_beat", 64'(beat_cnt_o), 64'(k));
    end
    check("fr_grant_held", 64'(grant_o), 64'b0100);
    step();
    check("fr_rel_busy", 64'(busy_o), 0);
    check("fr_rel_grant", 64'(grant_o), 0);
    check_log(2, 0, 16);
    step();
    check("fr_regrant", 64'(grant_o), 64'b0100);
    check("fr_regrant_beat", 64'(beat_cnt_o), 0);
    set_valid(4'b1100);
    for (int k = 0; k < 16; k++) step();
    check("fr_rel2_grant", 64'(grant_o), 0);
    step();
    check("fr_grant3", 64'(grant_o), 64'b1000);
    check("fr_data3", 64'(fifo_data_o), 64'(word(3, 0)));

    // backpressure mid-burst
    restart(0, 0, 0, 0);
    set_valid(4'b0010);
    step();
    step();
    step();
    check("bp_beat_pre", 64'(beat_cnt_o), 2);
    fifo_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_fvalid", 64'(fifo_valid_o), 1);
      check("bp_data", 64'(fifo_data_o), 64'(word(1, 2)));
      check("bp_ready", 64'(req_ready_o), 0);
      check("bp_beat", 64'(beat_cnt_o), 2);
      check("bp_grant", 64'(grant_o), 64'b0010);
      step();
    end
    fifo_ready_i = 1'b1;
    #1;
    check("bp_ready_back", 64'(req_ready_o), 64'b0010);
    step();
    check("bp_beat_post", 64'(beat_cnt_o), 3);
    check_log(1, 0, 3);

    // clear mid-burst: owner 3 at beat 5
    restart(0, 0, 0, 0);
    set_valid(4'b1000);
    step();
    check("clr_grant3", 64'(grant_o), 64'b1000);
    for (int k = 0; k < 5; k++) step();
    check("clr_beat5", 64'(beat_cnt_o), 5);
    set_valid(4'b1001);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    #1;
    check("clr_grant", 64'(grant_o), 0);
    check("clr_beat", 64'(beat_cnt_o), 0);
    check("clr_busy", 64'(busy_o), 0);
    check_log(3, 0, 6);
    step();
    check("clr_next_grant", 64'(grant_o), 64'b0001);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
